// File: rtl/apb_gpio_multi_if.sv
// APB bus bundle for apb_gpio_multi.
// Handshake: the master holds sel/write/addr/wData stable from setup until the
// cycle after ready; ready is high for exactly one cycle per transfer, and
// rData/subErr are only meaningful while ready is high (0 otherwise).
interface apb_gpio_multi_if #(
   parameter int AddrWidth = 8,
   parameter int DataWidth = 32
);
   logic                 sel;
   logic                 enable;
   logic                 write;
   logic [AddrWidth-1:0] addr;
   logic [DataWidth-1:0] wData;
   logic [DataWidth-1:0] rData;
   logic                 ready;
   logic                 subErr;

   modport master (
      output sel, enable, write, addr, wData,
      input  rData, ready, subErr
   );

   modport slave (
      input  sel, enable, write, addr, wData,
      output rData, ready, subErr
   );
endinterface

// File: rtl/apb_gpio_multi.sv
// Multi-port APB GPIO: per-port OUT/DIR, atomic SET/CLR/TGL, synchronised
// inputs, rise/fall edge capture into W1C STATUS, level irq, registered
// one-wait-state APB response.
module apb_gpio_multi #(
   parameter int NumPorts   = 2,
   parameter int PortWidth  = 16,
   parameter int DataWidth  = 32,
   parameter int AddrWidth  = 8,
   parameter int SyncStages = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   apb_gpio_multi_if.slave                 bus,
   input  logic [NumPorts*PortWidth-1:0]   pin_in,
   output logic [NumPorts*PortWidth-1:0]   pin_out,
   output logic [NumPorts*PortWidth-1:0]   pin_oe,
   output logic                            irq
);
   localparam int PinCount = NumPorts * PortWidth;
   localparam int IdxWidth = AddrWidth - 4;

   typedef logic [PortWidth-1:0] port_t;

   // per-port register file
   port_t out_q     [NumPorts];
   port_t dir_q     [NumPorts];
   port_t rise_en_q [NumPorts];
   port_t fall_en_q [NumPorts];
   port_t status_q  [NumPorts];

   // input synchroniser chain and edge history
   logic [PinCount-1:0] sync_q [SyncStages];
   logic [PinCount-1:0] sync_in;
   logic [PinCount-1:0] prev_q;

   // registered bus response
   logic                 ready_q;
   logic                 sub_err_q;
   logic [DataWidth-1:0] rdata_q;

   // address decode
   logic [3:0]          offset;
   logic [IdxWidth-1:0] port_idx;
   logic                port_ok;
   logic                acc_err;
   logic                start;
   logic                commit;
   port_t               wr_val;
   port_t               rd_val;
   logic [NumPorts-1:0] port_wr;
   port_t               status_clr [NumPorts];
   port_t               edge_d     [NumPorts];
   logic                unused_wdata;

   assign offset   = bus.addr[3:0];
   assign port_idx = bus.addr[AddrWidth-1:4];
   assign port_ok  = 32'(port_idx) < NumPorts;
   assign acc_err  = !port_ok || (offset > 4'd8) || (bus.write && (offset == 4'd2));
   // first access cycle: the edge ending it raises ready and loads the response
   assign start    = bus.sel & bus.enable & ~ready_q;
   // second access cycle: the edge ending it commits a write
   assign commit   = bus.sel & bus.enable & ready_q & bus.write & ~acc_err;
   assign wr_val   = bus.wData[PortWidth-1:0];
   // upper write-data bits are intentionally ignored
   assign unused_wdata = ^bus.wData;

   assign sync_in    = sync_q[SyncStages-1];
   assign bus.ready  = ready_q;
   assign bus.subErr = sub_err_q;
   assign bus.rData  = rdata_q;

   // per-port write strobes, W1C masks and qualified edge events
   always_comb begin
      port_wr = '0;
      for (int p = 0; p < NumPorts; p++) begin
         port_wr[p]    = commit && (port_idx == IdxWidth'(p));
         status_clr[p] = (port_wr[p] && (offset == 4'd8)) ? wr_val : '0;
         edge_d[p]     = (sync_in[p*PortWidth +: PortWidth] & ~prev_q[p*PortWidth +: PortWidth]
                          & rise_en_q[p])
                       | (~sync_in[p*PortWidth +: PortWidth] & prev_q[p*PortWidth +: PortWidth]
                          & fall_en_q[p]);
      end
   end

   // read data mux for the addressed port; IN mixes driven and sampled bits
   always_comb begin
      rd_val = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (port_idx == IdxWidth'(p)) begin
            case (offset)
               4'd0:    rd_val = out_q[p];
               4'd1:    rd_val = dir_q[p];
               4'd2:    rd_val = (dir_q[p] & out_q[p])
                               | (~dir_q[p] & sync_in[p*PortWidth +: PortWidth]);
               4'd6:    rd_val = rise_en_q[p];
               4'd7:    rd_val = fall_en_q[p];
               4'd8:    rd_val = status_q[p];
               default: rd_val = '0;
            endcase
         end
      end
   end

   // pad outputs and level interrupt straight from the flops
   always_comb begin
      irq = 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
         pin_out[p*PortWidth +: PortWidth] = out_q[p];
         pin_oe[p*PortWidth +: PortWidth]  = dir_q[p];
         irq = irq | (|status_q[p]);
      end
   end

   // input synchroniser and one-cycle edge history
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= pin_in;
         for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= sync_in;
      end
   end

   // register file updates; a new edge overrides a same-cycle W1C
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < NumPorts; p++) begin
            out_q[p]     <= '0;
            dir_q[p]     <= '0;
            rise_en_q[p] <= '0;
            fall_en_q[p] <= '0;
            status_q[p]  <= '0;
         end
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            if (port_wr[p]) begin
               case (offset)
                  4'd0:    out_q[p]     <= wr_val;
                  4'd1:    dir_q[p]     <= wr_val;
                  4'd3:    out_q[p]     <= out_q[p] | wr_val;
                  4'd4:    out_q[p]     <= out_q[p] & ~wr_val;
                  4'd5:    out_q[p]     <= out_q[p] ^ wr_val;
                  4'd6:    rise_en_q[p] <= wr_val;
                  4'd7:    fall_en_q[p] <= wr_val;
                  default: ;
               endcase
            end
            status_q[p] <= (status_q[p] & ~status_clr[p]) | edge_d[p];
         end
      end
   end

   // APB response: ready pulses on the second access cycle with rData/subErr
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q   <= 1'b0;
         sub_err_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ready_q   <= start;
         sub_err_q <= start & acc_err;
         rdata_q   <= (start && !acc_err && !bus.write) ? DataWidth'(rd_val) : '0;
      end
   end
endmodule

// File: tb/tb_apb_gpio_multi.sv
// Self-checking bench for apb_gpio_multi (2 ports x 16 pins, 2 sync stages).
module tb_apb_gpio_multi;
   localparam int NP   = 2;
   localparam int PW   = 16;
   localparam int DW   = 32;
   localparam int AW   = 8;
   localparam int SS   = 2;
   localparam int PINS = NP * PW;
   localparam int HD   = SS + 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [PINS-1:0] pin_in = '0;
   logic [PINS-1:0] pin_out;
   logic [PINS-1:0] pin_oe;
   logic            irq;

   int tests = 0;
   int fails = 0;

   apb_gpio_multi_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

   apb_gpio_multi #(
      .NumPorts(NP), .PortWidth(PW), .DataWidth(DW), .AddrWidth(AW), .SyncStages(SS)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // hist[i] = pin_in as sampled i edges ago; a pad change sampled at edge j
   // becomes visible on IN after SS-1 further edges and lands in STATUS
   // SS edges after it was sampled.
   logic [PINS-1:0] hist [HD];
   logic [PW-1:0]   m_out [NP];
   logic [PW-1:0]   m_dir [NP];
   logic [PW-1:0]   m_rise [NP];
   logic [PW-1:0]   m_fall [NP];
   logic [PW-1:0]   m_status [NP];
   bit              mdl_go = 0;
   int              mdl_port;
   int              mdl_off;
   logic [PW-1:0]   mdl_wd;
   bit              exp_ready = 0;
   bit              chk_en = 0;

   always @(posedge clk) begin
      logic [PW-1:0] now_v, old_v, ev, clr;
      if (reset) begin
         for (int i = 0; i < HD; i++) hist[i] = '0;
         for (int p = 0; p < NP; p++) begin
            m_out[p] = '0; m_dir[p] = '0; m_rise[p] = '0; m_fall[p] = '0; m_status[p] = '0;
         end
         mdl_go = 0;
      end else begin
         for (int i = HD - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = pin_in;
         for (int p = 0; p < NP; p++) begin
            now_v = hist[SS][p*PW +: PW];
            old_v = hist[SS+1][p*PW +: PW];
            ev    = (now_v & ~old_v & m_rise[p]) | (~now_v & old_v & m_fall[p]);
            clr   = '0;
            if (mdl_go && mdl_port == p) begin
               case (mdl_off)
                  0: m_out[p]  = mdl_wd;
                  1: m_dir[p]  = mdl_wd;
                  3: m_out[p]  = m_out[p] | mdl_wd;
                  4: m_out[p]  = m_out[p] & ~mdl_wd;
                  5: m_out[p]  = m_out[p] ^ mdl_wd;
                  6: m_rise[p] = mdl_wd;
                  7: m_fall[p] = mdl_wd;
                  8: clr       = mdl_wd;
                  default: ;
               endcase
            end
            m_status[p] = (m_status[p] & ~clr) | ev;
         end
         mdl_go = 0;
      end
   end

   function automatic logic [DW-1:0] mdl_read(input int port, input int off);
      logic [PW-1:0] v;
      case (off)
         0: v = m_out[port];
         1: v = m_dir[port];
         2: v = (m_dir[port] & m_out[port]) | (~m_dir[port] & hist[SS-1][port*PW +: PW]);
         6: v = m_rise[port];
         7: v = m_fall[port];
         8: v = m_status[port];
         default: v = '0;
      endcase
      return DW'(v);
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // every-cycle compare of pads, irq and idle response against the model
   always @(negedge clk) begin
      logic [PINS-1:0] e_out, e_oe;
      logic            e_irq;
      if (chk_en) begin
         e_irq = 1'b0;
         for (int p = 0; p < NP; p++) begin
            e_out[p*PW +: PW] = m_out[p];
            e_oe[p*PW +: PW]  = m_dir[p];
            e_irq = e_irq | (|m_status[p]);
         end
         check("pin_out", pin_out, e_out);
         check("pin_oe", pin_oe, e_oe);
         check("irq", DW'(irq), DW'(e_irq));
         check("ready", DW'(bus.ready), DW'(exp_ready));
         if (!exp_ready) begin
            check("rdata_idle", bus.rData, '0);
            check("suberr_idle", DW'(bus.subErr), '0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One APB transfer; pin_or is OR-ed onto pin_in at the setup cycle.
   task automatic apb(input bit wr, input int port, input int off, input logic [DW-1:0] wd,
                      input logic [PINS-1:0] pin_or, output logic [DW-1:0] rd, output bit err);
      logic [DW-1:0] e_rd;
      bit            e_err;
      @(posedge clk); #1;
      bus.sel = 1'b1; bus.enable = 1'b0; bus.write = wr;
      bus.addr = {port[3:0], off[3:0]}; bus.wData = wd;
      pin_in = pin_in | pin_or;
      @(posedge clk); #1;
      bus.enable = 1'b1;
      @(negedge clk);
      e_err = (port >= NP) || (off > 8) || (wr && off == 2);
      e_rd  = (e_err || wr) ? '0 : mdl_read(port, off);
      @(posedge clk); #1;
      exp_ready = 1;
      if (wr && !e_err) begin
         mdl_port = port; mdl_off = off; mdl_wd = wd[PW-1:0]; mdl_go = 1;
      end
      @(negedge clk);
      rd  = bus.rData;
      err = bus.subErr;
      if (!wr) check("rdata", bus.rData, e_rd);
      check("suberr", DW'(bus.subErr), DW'(e_err));
      @(posedge clk); #1;
      exp_ready = 0;
      bus.sel = 1'b0; bus.enable = 1'b0; bus.write = 1'b0;
   endtask

   // Write whose enable drops in the ready cycle: nothing may commit.
   task automatic apb_abandon(input int port, input int off, input logic [DW-1:0] wd);
      @(posedge clk); #1;
      bus.sel = 1'b1; bus.enable = 1'b0; bus.write = 1'b1;
      bus.addr = {port[3:0], off[3:0]}; bus.wData = wd;
      @(posedge clk); #1;
      bus.enable = 1'b1;
      @(posedge clk); #1;
      exp_ready = 1;
      bus.enable = 1'b0;
      @(posedge clk); #1;
      exp_ready = 0;
      bus.sel = 1'b0; bus.write = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [DW-1:0] rd;
      bit            err;
      bus.sel = 1'b0; bus.enable = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wData = '0;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      chk_en = 1;

      // 1: reset state
      @(negedge clk);
      check("rst_pin_out", pin_out, '0);
      check("rst_irq", DW'(irq), '0);
      apb(0, 0, 0, '0, '0, rd, err); check("rst_out", rd, 32'h0);
      apb(0, 0, 1, '0, '0, rd, err); check("rst_dir", rd, 32'h0);
      apb(0, 0, 8, '0, '0, rd, err); check("rst_status", rd, 32'h0);
      check("rst_err", DW'(err), '0);

      // 2: atomic output ops on port 1
      apb(1, 1, 0, 32'h0000_00F0, '0, rd, err);
      apb(1, 1, 3, 32'h0000_0003, '0, rd, err);
      apb(1, 1, 4, 32'h0000_0010, '0, rd, err);
      apb(1, 1, 5, 32'hFFFF_0101, '0, rd, err);
      @(negedge clk);
      check("p1_pins", DW'(pin_out[31:16]), 32'h01E2);
      apb(0, 1, 0, '0, '0, rd, err); check("p1_out", rd, 32'h0000_01E2);

      // 3: IN mixes OUT (driven bits) with synchronised pads
      apb(1, 0, 1, 32'h0000_00FF, '0, rd, err);
      apb(1, 0, 0, 32'h0000_0055, '0, rd, err);
      pin_in[15:0] = 16'hAB00;
      idle(SS + 1);
      apb(0, 0, 2, '0, '0, rd, err); check("p0_in", rd, 32'h0000_AB55);
      @(negedge clk);
      check("p0_oe", DW'(pin_oe[15:0]), 32'h00FF);

      // 4: edge capture, irq, W1C
      apb(1, 0, 6, 32'h0000_0001, '0, rd, err);
      apb(1, 0, 7, 32'h0000_0002, '0, rd, err);
      pin_in[1] = 1'b1;
      idle(4);
      apb(0, 0, 8, '0, '0, rd, err); check("no_edge", rd, 32'h0);
      pin_in[0] = 1'b1; pin_in[1] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); check("irq_early", DW'(irq), '0);
      @(posedge clk);
      @(negedge clk); check("irq_set", DW'(irq), 32'h1);
      apb(0, 0, 8, '0, '0, rd, err); check("status3", rd, 32'h0000_0003);
      apb(1, 0, 8, 32'h0000_0001, '0, rd, err);
      apb(0, 0, 8, '0, '0, rd, err); check("status2", rd, 32'h0000_0002);
      @(negedge clk); check("irq_still", DW'(irq), 32'h1);
      apb(1, 0, 8, 32'h0000_0002, '0, rd, err);
      @(negedge clk); check("irq_clear", DW'(irq), '0);

      // 5: new edge and W1C on the same edge -> bit stays set
      pin_in[0] = 1'b0; idle(4);
      pin_in[0] = 1'b1; idle(4);
      pin_in[0] = 1'b0; idle(4);
      apb(0, 0, 8, '0, '0, rd, err); check("status_pre", rd, 32'h0000_0001);
      apb(1, 0, 8, 32'h0000_0001, 32'h0000_0001, rd, err);
      apb(0, 0, 8, '0, '0, rd, err); check("set_wins", rd, 32'h0000_0001);
      apb(1, 0, 8, 32'h0000_0001, '0, rd, err);
      apb(0, 0, 8, '0, '0, rd, err); check("w1c_plain", rd, 32'h0);

      // 6: slave errors leave state untouched
      apb(0, 0, 9, '0, '0, rd, err);   check("err_off9", DW'(err), 32'h1);
      apb(1, 0, 12, 32'hFFFF, '0, rd, err); check("err_off12", DW'(err), 32'h1);
      apb(1, 2, 0, 32'hFFFF, '0, rd, err); check("err_port2", DW'(err), 32'h1);
      apb(1, 0, 2, 32'h1234, '0, rd, err); check("err_wr_in", DW'(err), 32'h1);
      apb(0, 0, 0, '0, '0, rd, err);   check("p0_out_kept", rd, 32'h0000_0055);
      apb(0, 0, 3, '0, '0, rd, err);   check("set_reads0", rd, 32'h0);
      check("set_rd_err", DW'(err), '0);
      apb(0, 1, 0, '0, '0, rd, err);   check("p1_out_kept", rd, 32'h0000_01E2);

      // abandoned write
      apb_abandon(1, 0, 32'hDEAD);
      apb(0, 1, 0, '0, '0, rd, err);   check("abandon", rd, 32'h0000_01E2);

      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
